// File: rtl/amiga_dram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amiga_dram_pkg
// Purpose  : Shared state encoding and constants for the Amiga DRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package amiga_dram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ROW     = 3'd1,
        COL     = 3'd2,
        ACK     = 3'd3,
        PRE     = 3'd4,
        REF_CAS = 3'd5,
        REF_RAS = 3'd6,
        REF_END = 3'd7
    } dram_state_t;

    localparam int PRECHARGE_CYCLES = 2;

    function automatic int nbank(input int bank_bits);
        return 1 << bank_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amiga_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : amiga_refresh_timer
// Purpose  : Free-running refresh interval counter with a single pending flag.
// Revision : 1.0 - initial release
// ============================================================================
module amiga_refresh_timer #(
    parameter int REFRESH_DIV = 56
) (
    input  logic CLK,
    input  logic _RST,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] r_count;
    logic          r_pending;
    logic          w_expire;

    assign w_expire = (r_count == '0);

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            r_count   <= CW'(REFRESH_DIV - 1);
            r_pending <= 1'b0;
        end else begin
            r_count <= w_expire ? CW'(REFRESH_DIV - 1) : r_count - 1'b1;
            // A new expiry outranks a same-cycle clear so no refresh is lost.
            if (w_expire)
                r_pending <= 1'b1;
            else if (clear)
                r_pending <= 1'b0;
        end
    end

    // Expiry is visible in the same cycle so the FSM can favour it over an access.
    assign pending = r_pending | w_expire;

endmodule
`default_nettype wire

// File: rtl/amiga_dram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : amiga_dram_ctl
// Purpose  : 68000-bus DRAM controller with CBR refresh and write-once lock.
// Revision : 1.0 - initial release
// ============================================================================
module amiga_dram_ctl
    import amiga_dram_pkg::*;
#(
    parameter int ROW_BITS    = 8,
    parameter int BANK_BITS   = 1,
    parameter int REFRESH_DIV = 56,
    parameter int WPRO_EN     = 1
) (
    input  logic                            CLK,
    input  logic                            _RST,
    input  logic                            _AS,
    input  logic                            _UDS,
    input  logic                            _LDS,
    input  logic                            R_W,
    input  logic [2*ROW_BITS+BANK_BITS-1:0] A,
    input  logic                            SEL,
    input  logic                            WPRO_SET,
    output logic                            _DTACK,
    output logic [ROW_BITS-1:0]             MA,
    output logic [nbank(BANK_BITS)-1:0]     _RAS,
    output logic [nbank(BANK_BITS)-1:0]     _UCAS,
    output logic [nbank(BANK_BITS)-1:0]     _LCAS,
    output logic                            _WE,
    output logic                            _WPRO,
    output logic                            BUSY
);

    localparam int NBANK = nbank(BANK_BITS);
    localparam int AW    = 2*ROW_BITS + BANK_BITS;
    localparam int PRE_W = $clog2(PRECHARGE_CYCLES + 1);

    dram_state_t          r_state;
    logic [NBANK-1:0]     r_ras, r_ucas, r_lcas;
    logic [ROW_BITS-1:0]  r_ma, r_col;
    logic [BANK_BITS-1:0] r_bank;
    logic [PRE_W-1:0]     r_pre_cnt;
    logic                 r_we, r_dtack, r_wpro, r_busy, r_block;
    logic                 w_ref_pending, w_ref_clear;
    logic [NBANK-1:0]     w_req_sel, w_cur_sel;

    assign w_req_sel   = NBANK'(1) << A[AW-1 -: BANK_BITS];
    assign w_cur_sel   = NBANK'(1) << r_bank;
    assign w_ref_clear = (r_state == REF_END);

    amiga_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_timer (
        .CLK     (CLK),
        ._RST    (_RST),
        .clear   (w_ref_clear),
        .pending (w_ref_pending)
    );

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            r_state   <= IDLE;
            r_ras     <= '1;
            r_ucas    <= '1;
            r_lcas    <= '1;
            r_we      <= 1'b1;
            r_dtack   <= 1'b1;
            r_wpro    <= 1'b1;
            r_ma      <= '0;
            r_busy    <= 1'b0;
            r_col     <= '0;
            r_bank    <= '0;
            r_block   <= 1'b0;
            r_pre_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (WPRO_EN != 0 && WPRO_SET)
                        r_wpro <= 1'b0;
                    if (w_ref_pending) begin
                        r_state <= REF_CAS;
                        r_ucas  <= '0;
                        r_lcas  <= '0;
                        r_busy  <= 1'b1;
                    end else if (!_AS && SEL) begin
                        r_state <= ROW;
                        r_col   <= A[ROW_BITS-1:0];
                        r_bank  <= A[AW-1 -: BANK_BITS];
                        r_ma    <= A[2*ROW_BITS-1 -: ROW_BITS];
                        r_ras   <= ~w_req_sel;
                        // A locked part still sees RAS, but never WE or CAS on a write.
                        r_we    <= R_W | ~r_wpro;
                        r_block <= ~R_W & ~r_wpro;
                        r_busy  <= 1'b1;
                    end
                end
                ROW: begin
                    if (_AS) begin
                        r_state   <= PRE;
                        r_ras     <= '1;
                        r_we      <= 1'b1;
                        r_pre_cnt <= '0;
                    end else begin
                        r_state <= COL;
                        r_ma    <= r_col;
                        if (!r_block) begin
                            r_ucas <= ~(w_cur_sel & {NBANK{~_UDS}});
                            r_lcas <= ~(w_cur_sel & {NBANK{~_LDS}});
                        end
                    end
                end
                COL: begin
                    if (_AS) begin
                        r_state   <= PRE;
                        r_ras     <= '1;
                        r_ucas    <= '1;
                        r_lcas    <= '1;
                        r_we      <= 1'b1;
                        r_pre_cnt <= '0;
                    end else begin
                        r_state <= ACK;
                        r_dtack <= 1'b0;
                    end
                end
                ACK: begin
                    if (_AS) begin
                        r_state   <= PRE;
                        r_ras     <= '1;
                        r_ucas    <= '1;
                        r_lcas    <= '1;
                        r_we      <= 1'b1;
                        r_dtack   <= 1'b1;
                        r_pre_cnt <= '0;
                    end
                end
                PRE: begin
                    if (r_pre_cnt == PRE_W'(PRECHARGE_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 1'b1;
                    end
                end
                REF_CAS: begin
                    r_state <= REF_RAS;
                    r_ras   <= '0;
                    r_we    <= 1'b1;
                end
                REF_RAS: begin
                    r_state <= REF_END;
                    r_ras   <= '1;
                    r_ucas  <= '1;
                    r_lcas  <= '1;
                end
                REF_END: begin
                    r_state   <= PRE;
                    r_pre_cnt <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign _DTACK = r_dtack;
    assign MA     = r_ma;
    assign _RAS   = r_ras;
    assign _UCAS  = r_ucas;
    assign _LCAS  = r_lcas;
    assign _WE    = r_we;
    assign _WPRO  = r_wpro;
    assign BUSY   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_amiga_dram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_amiga_dram_ctl
// Purpose  : Directed vector bench for amiga_dram_ctl (default and wide builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_amiga_dram_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, r_w = 1'b1;
    logic        sel = 1'b0, wpro_set = 1'b0;
    logic [16:0] a  = '0;
    logic [19:0] a2 = '0;

    logic        dtack_n, we_n, wpro_n, busy;
    logic [7:0]  ma;
    logic [1:0]  ras_n, ucas_n, lcas_n;
    logic        dtack2, we2, wpro2, busy2;
    logic [8:0]  ma2;
    logic [3:0]  ras2, ucas2, lcas2;

    int total = 0, passed = 0, cyc = 0, refcnt = 0;

    always #5 clk = ~clk;

    amiga_dram_ctl dut (
        .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n),
        .R_W(r_w), .A(a), .SEL(sel), .WPRO_SET(wpro_set),
        ._DTACK(dtack_n), .MA(ma), ._RAS(ras_n), ._UCAS(ucas_n), ._LCAS(lcas_n),
        ._WE(we_n), ._WPRO(wpro_n), .BUSY(busy)
    );

    amiga_dram_ctl #(.ROW_BITS(9), .BANK_BITS(2), .REFRESH_DIV(56), .WPRO_EN(0)) dut2 (
        .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n),
        .R_W(r_w), .A(a2), .SEL(sel), .WPRO_SET(wpro_set),
        ._DTACK(dtack2), .MA(ma2), ._RAS(ras2), ._UCAS(ucas2), ._LCAS(lcas2),
        ._WE(we2), ._WPRO(wpro2), .BUSY(busy2)
    );

    typedef struct packed {
        logic [16:0] a;
        logic        rw;
        logic        uds;
        logic        lds;
        logic [1:0]  ras1;
        logic [7:0]  ma1;
        logic        we1;
        logic [7:0]  ma2;
        logic [1:0]  ucas2;
        logic [1:0]  lcas2;
    } vec_t;

    vec_t vec [4];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic idle_bus();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; r_w = 1'b1; sel = 1'b0; wpro_set = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic start(input logic [16:0] addr, input logic rw, input logic u, input logic l);
        a = addr; r_w = rw; uds_n = u; lds_n = l; sel = 1'b1; as_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{17'h1_2345, 1'b1, 1'b0, 1'b0, 2'b01, 8'h23, 1'b1, 8'h45, 2'b01, 2'b01};
        vec[1] = '{17'h0_ABCD, 1'b0, 1'b0, 1'b1, 2'b10, 8'hAB, 1'b0, 8'hCD, 2'b10, 2'b11};
        vec[2] = '{17'h1_00FF, 1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 8'hFF, 2'b11, 2'b11};
        vec[3] = '{17'h0_7F80, 1'b0, 1'b1, 1'b0, 2'b10, 8'h7F, 1'b0, 8'h80, 2'b11, 2'b10};

        // Reset state
        do_reset();
        chk("rst ras", ras_n, 2'b11);
        chk("rst ucas", ucas_n, 2'b11);
        chk("rst lcas", lcas_n, 2'b11);
        chk("rst we", we_n, 1'b1);
        chk("rst dtack", dtack_n, 1'b1);
        chk("rst wpro", wpro_n, 1'b1);
        chk("rst ma", ma, 8'h00);
        chk("rst busy", busy, 1'b0);

        // Table-driven single accesses
        for (int i = 0; i < 4; i++) begin
            do_reset();
            step();
            start(vec[i].a, vec[i].rw, vec[i].uds, vec[i].lds);
            step();
            chk($sformatf("v%0d c1 ras", i), ras_n, vec[i].ras1);
            chk($sformatf("v%0d c1 ma", i), ma, vec[i].ma1);
            chk($sformatf("v%0d c1 we", i), we_n, vec[i].we1);
            chk($sformatf("v%0d c1 busy", i), busy, 1'b1);
            step();
            chk($sformatf("v%0d c2 ma", i), ma, vec[i].ma2);
            chk($sformatf("v%0d c2 ucas", i), ucas_n, vec[i].ucas2);
            chk($sformatf("v%0d c2 lcas", i), lcas_n, vec[i].lcas2);
            chk($sformatf("v%0d c2 dtack", i), dtack_n, 1'b1);
            step();
            chk($sformatf("v%0d c3 dtack", i), dtack_n, 1'b0);
            step();
            chk($sformatf("v%0d hold dtack", i), dtack_n, 1'b0);
            chk($sformatf("v%0d hold ras", i), ras_n, vec[i].ras1);
            as_n = 1'b1;
            step();
            chk($sformatf("v%0d pre dtack", i), dtack_n, 1'b1);
            chk($sformatf("v%0d pre strobes", i), {ras_n, ucas_n, lcas_n}, 6'h3F);
            chk($sformatf("v%0d pre busy1", i), busy, 1'b1);
            step();
            chk($sformatf("v%0d pre busy2", i), busy, 1'b1);
            step();
            chk($sformatf("v%0d idle busy", i), busy, 1'b0);
        end

        // Refresh colliding with an access in the same IDLE cycle, then a
        // long ACK spanning two further expiries that must collapse into one.
        do_reset();
        repeat (54) step();
        chk("col pre-expiry busy", busy, 1'b0);
        step();
        start(17'h1_2345, 1'b1, 1'b0, 1'b0);
        step();
        chk("col ref_cas cas", {ucas_n, lcas_n}, 4'h0);
        chk("col ref_cas ras", ras_n, 2'b11);
        step();
        chk("col ref_ras ras", ras_n, 2'b00);
        chk("col ref_ras we", we_n, 1'b1);
        step();
        chk("col ref_end strobes", {ras_n, ucas_n, lcas_n}, 6'h3F);
        chk("col ref_end busy", busy, 1'b1);
        step();
        chk("col pre1 busy", busy, 1'b1);
        step();
        chk("col pre2 busy", busy, 1'b1);
        step();
        chk("col idle busy", busy, 1'b0);
        step();
        chk("col row ras", ras_n, 2'b01);
        chk("col row ma", ma, 8'h23);
        step();
        chk("col col ma", ma, 8'h45);
        step();
        chk("col ack dtack", dtack_n, 1'b0);
        while (cyc < 175) step();
        chk("long ack dtack", dtack_n, 1'b0);
        chk("long ack ras", ras_n, 2'b01);
        as_n = 1'b1;
        sel = 1'b0;
        refcnt = 0;
        repeat (40) begin
            step();
            if (ucas_n == 2'b00 && lcas_n == 2'b00 && ras_n == 2'b11) refcnt++;
        end
        chk("dropped expiry refresh count", refcnt, 1);
        chk("after refresh busy", busy, 1'b0);

        // Write-once lock; the WPRO_EN=0 wide build writes to bank 3 meanwhile
        do_reset();
        step();
        wpro_set = 1'b1;
        step();
        wpro_set = 1'b0;
        chk("wpro locked", wpro_n, 1'b0);
        chk("wpro disabled build", wpro2, 1'b1);
        a2 = {2'b11, 9'h1A5, 9'h0C3};
        start(17'h0_1234, 1'b0, 1'b1, 1'b0);
        step();
        chk("wp c1 ras", ras_n, 2'b10);
        chk("wp c1 we", we_n, 1'b1);
        chk("w2 c1 ras", ras2, 4'b0111);
        chk("w2 c1 ma", ma2, 9'h1A5);
        chk("w2 c1 we", we2, 1'b0);
        step();
        chk("wp c2 cas", {ucas_n, lcas_n}, 4'hF);
        chk("wp c2 we", we_n, 1'b1);
        chk("w2 c2 ma", ma2, 9'h0C3);
        chk("w2 c2 lcas", lcas2, 4'b0111);
        chk("w2 c2 ucas", ucas2, 4'b1111);
        step();
        chk("wp c3 dtack", dtack_n, 1'b0);
        chk("wp c3 we", we_n, 1'b1);
        chk("w2 c3 dtack", dtack2, 1'b0);
        as_n = 1'b1;
        repeat (3) step();
        chk("wp idle busy", busy, 1'b0);
        chk("wpro sticky", wpro_n, 1'b0);
        chk("wpro disabled sticky", wpro2, 1'b1);

        // Abort: _AS rises during cycle 2
        do_reset();
        step();
        start(17'h0_5678, 1'b1, 1'b0, 1'b0);
        step();
        chk("ab c1 ras", ras_n, 2'b10);
        step();
        chk("ab c2 dtack", dtack_n, 1'b1);
        as_n = 1'b1;
        step();
        chk("ab c3 dtack", dtack_n, 1'b1);
        chk("ab c3 strobes", {ras_n, ucas_n, lcas_n}, 6'h3F);
        chk("ab c3 busy", busy, 1'b1);
        step();
        chk("ab c4 dtack", dtack_n, 1'b1);
        chk("ab c4 busy", busy, 1'b1);
        step();
        chk("ab c5 busy", busy, 1'b0);
        chk("ab c5 dtack", dtack_n, 1'b1);

        // Asynchronous reset while in ACK, then refresh timing from release
        do_reset();
        step();
        start(17'h1_2345, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        chk("ra ack dtack", dtack_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ra strobes", {ras_n, ucas_n, lcas_n}, 6'h3F);
        chk("ra dtack", dtack_n, 1'b1);
        chk("ra busy", busy, 1'b0);
        chk("ra ma", ma, 8'h00);
        chk("ra we", we_n, 1'b1);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (55) step();
        chk("ra no refresh at 55", {busy, ucas_n}, 3'b011);
        step();
        chk("ra refresh at 56 cas", {ucas_n, lcas_n}, 4'h0);
        chk("ra refresh at 56 busy", busy, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
